// File: rtl/zeroriscy_instr_aligner_pkg.sv
// Shared definitions for the instruction aligner.
// State encoding and the RVC uncompressed opcode marker.
package zeroriscy_defines;

  typedef enum logic {
    S_ALIGNED = 1'b0,
    S_HOLD    = 1'b1
  } align_state_e;

  localparam logic [1:0] OPCODE_UNCOMPRESSED = 2'b11;

  function automatic logic is_compressed(
    input logic [15:0] half
  );
    return half[1:0] != OPCODE_UNCOMPRESSED;
  endfunction

endpackage

// File: rtl/zeroriscy_instr_aligner.sv
// RV32IC aligner between prefetch FIFO and IF/ID.
// Emits one 16/32-bit instruction per handshake.
module zeroriscy_instr_aligner
  import zeroriscy_defines::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  branch_i,
  input  logic                  fetch_valid_i,
  input  logic [31:0]           fetch_rdata_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_ready_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  instr_is_compressed_o,
  output logic                  busy_o
);

  align_state_e          state_q, state_d;
  logic [15:0]           hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [15:0]           lo, hi;

  assign lo = fetch_rdata_i[15:0];
  assign hi = fetch_rdata_i[31:16];

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_addr_d   = hold_addr_q;
    fetch_ready_o = 1'b0;
    instr_valid_o = 1'b0;
    instr_rdata_o = fetch_rdata_i;
    instr_addr_o  = fetch_addr_i;

    if (branch_i) begin
      state_d     = S_ALIGNED;
      hold_d      = '0;
      hold_addr_d = '0;
    end else begin
      unique case (state_q)
        S_ALIGNED: begin
          if (fetch_valid_i) begin
            if (!fetch_addr_i[1]) begin
              instr_valid_o = 1'b1;
              if (is_compressed(lo)) begin
                instr_rdata_o = {16'h0, lo};
                if (instr_ready_i) begin
                  fetch_ready_o = 1'b1;
                  hold_d        = hi;
                  hold_addr_d   = fetch_addr_i
                                + ADDR_WIDTH'(2);
                  state_d       = S_HOLD;
                end
              end else if (instr_ready_i) begin
                fetch_ready_o = 1'b1;
              end
            end else if (is_compressed(hi)) begin
              instr_valid_o = 1'b1;
              instr_rdata_o = {16'h0, hi};
              fetch_ready_o = instr_ready_i;
            end else begin
              // lower half is dead; park upper half
              fetch_ready_o = 1'b1;
              hold_d        = hi;
              hold_addr_d   = fetch_addr_i;
              state_d       = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          instr_addr_o = hold_addr_q;
          if (is_compressed(hold_q)) begin
            instr_valid_o = 1'b1;
            instr_rdata_o = {16'h0, hold_q};
            if (instr_ready_i) begin
              state_d = S_ALIGNED;
            end
          end else begin
            instr_valid_o = fetch_valid_i;
            instr_rdata_o = {lo, hold_q};
            if (fetch_valid_i && instr_ready_i) begin
              fetch_ready_o = 1'b1;
              hold_d        = hi;
              hold_addr_d   = hold_addr_q
                            + ADDR_WIDTH'(4);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_is_compressed_o =
    instr_rdata_o[1:0] != OPCODE_UNCOMPRESSED;
  assign busy_o = (state_q == S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ALIGNED;
      hold_q      <= '0;
      hold_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_addr_q <= hold_addr_d;
    end
  end

endmodule

// File: tb/tb_zeroriscy_instr_aligner.sv
// Directed bench for zeroriscy_instr_aligner.
// One table row per clock cycle of stimulus.
module tb_zeroriscy_instr_aligner;

  logic        clk;
  logic        rst_n;
  logic        branch_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_ready_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_addr_o;
  logic        instr_is_compressed_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  zeroriscy_instr_aligner #(.ADDR_WIDTH(32)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .branch_i              (branch_i),
    .fetch_valid_i         (fetch_valid_i),
    .fetch_rdata_i         (fetch_rdata_i),
    .fetch_addr_i          (fetch_addr_i),
    .fetch_ready_o         (fetch_ready_o),
    .instr_valid_o         (instr_valid_o),
    .instr_ready_i         (instr_ready_i),
    .instr_rdata_o         (instr_rdata_o),
    .instr_addr_o          (instr_addr_o),
    .instr_is_compressed_o (instr_is_compressed_o),
    .busy_o                (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic        fv;
    logic [31:0] rd;
    logic [31:0] ad;
    logic        ir;
    logic        e_fr;
    logic        e_iv;
    logic [31:0] e_id;
    logic [31:0] e_ia;
    logic        e_ic;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic br, input logic fv,
    input logic [31:0] rd, input logic [31:0] ad,
    input logic ir, input logic fr, input logic iv,
    input logic [31:0] id, input logic [31:0] ia,
    input logic ic, input logic busy
  );
    vec_t v;
    v.br = br; v.fv = fv; v.rd = rd; v.ad = ad;
    v.ir = ir; v.e_fr = fr; v.e_iv = iv;
    v.e_id = id; v.e_ia = ia; v.e_ic = ic;
    v.e_busy = busy;
    vq.push_back(v);
  endtask

  task automatic chk(
    input string nm, input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    branch_i      = v.br;
    fetch_valid_i = v.fv;
    fetch_rdata_i = v.rd;
    fetch_addr_i  = v.ad;
    instr_ready_i = v.ir;
  endtask

  task automatic check_row(input int i, input vec_t v);
    string s;
    s = $sformatf("row%0d", i);
    chk({s, ".fetch_ready"}, 32'(fetch_ready_o),
        32'(v.e_fr));
    chk({s, ".valid"}, 32'(instr_valid_o),
        32'(v.e_iv));
    chk({s, ".busy"}, 32'(busy_o), 32'(v.e_busy));
    if (v.e_iv) begin
      chk({s, ".rdata"}, instr_rdata_o, v.e_id);
      chk({s, ".addr"}, instr_addr_o, v.e_ia);
      chk({s, ".compressed"},
          32'(instr_is_compressed_o), 32'(v.e_ic));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive('{default: '0});

    // aligned 32-bit stream
    add(0,1,32'h00000013,32'h100,1, 1,1,32'h00000013,32'h100,0,0);
    add(0,1,32'h00100093,32'h104,1, 1,1,32'h00100093,32'h104,0,0);
    // two compressed in one word
    add(0,1,32'h00010001,32'h200,1, 1,1,32'h00000001,32'h200,1,0);
    add(0,1,32'hDEADBEEF,32'h204,1, 0,1,32'h00000001,32'h202,1,1);
    // straddling 32-bit
    add(0,1,32'h00130001,32'h300,1, 1,1,32'h00000001,32'h300,1,0);
    add(0,1,32'h00000000,32'h304,1, 1,1,32'h00000013,32'h302,0,1);
    add(0,0,32'h0,32'h0,1,          0,1,32'h00000000,32'h306,1,1);
    // misaligned branch target, uncompressed upper half
    add(0,1,32'h00930000,32'h402,1, 1,0,32'h0,32'h0,0,0);
    add(0,1,32'h00000010,32'h404,1, 1,1,32'h00100093,32'h402,0,1);
    add(0,0,32'h0,32'h0,1,          0,1,32'h00000000,32'h406,1,1);
    // backpressure on compressed output
    for (int k = 0; k < 3; k++)
      add(0,1,32'h00010005,32'h500,0, 0,1,32'h00000005,32'h500,1,0);
    add(0,1,32'h00010005,32'h500,1, 1,1,32'h00000005,32'h500,1,0);
    add(0,0,32'h0,32'h0,0,          0,1,32'h00000001,32'h502,1,1);
    // branch while holding
    add(1,1,32'h12345678,32'h600,1, 0,0,32'h0,32'h0,0,1);
    add(0,1,32'h00000013,32'h600,1, 1,1,32'h00000013,32'h600,0,0);
    // address wrap
    add(0,1,32'h00130000,32'hFFFFFFFE,1, 1,0,32'h0,32'h0,0,0);
    add(0,1,32'h00000000,32'h00000000,1,
        1,1,32'h00000013,32'hFFFFFFFE,0,1);
    add(0,0,32'h0,32'h0,1,          0,1,32'h00000000,32'h00000002,1,1);
    // misaligned target, compressed upper half
    add(0,1,32'h00050000,32'h702,1, 1,1,32'h00000005,32'h702,1,0);
    add(0,0,32'h0,32'h0,1,          0,0,32'h0,32'h0,0,0);
    // held uncompressed half waits for fetch, then stalls
    add(0,1,32'h00130001,32'h800,1, 1,1,32'h00000001,32'h800,1,0);
    add(0,0,32'h0,32'h0,1,          0,0,32'h0,32'h0,0,1);
    add(0,1,32'h00000000,32'h804,0, 0,1,32'h00000013,32'h802,0,1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", 32'(busy_o), 32'd0);
    chk("reset.valid", 32'(instr_valid_o), 32'd0);
    chk("reset.fetch_ready", 32'(fetch_ready_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      check_row(i, vq[i]);
    end

    // async reset while holding: clears without a clock edge
    @(negedge clk);
    drive('{default: '0});
    #1;
    chk("pre_rst.busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst.busy", 32'(busy_o), 32'd0);
    chk("async_rst.valid", 32'(instr_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h00000013;
    fetch_addr_i  = 32'h900;
    instr_ready_i = 1'b1;
    #1;
    chk("post_rst.valid", 32'(instr_valid_o), 32'd1);
    chk("post_rst.rdata", instr_rdata_o, 32'h00000013);
    chk("post_rst.addr", instr_addr_o, 32'h900);
    chk("post_rst.fetch_ready", 32'(fetch_ready_o), 32'd1);
    @(posedge clk);
    #1;
    chk("post_rst.busy", 32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zeroriscy_instr_aligner.md
Name: zeroriscy_instr_aligner

Overview:
- Sits between the prefetch buffer's output FIFO and the IF/ID pipeline register. It consumes word-aligned 32-bit fetch words, each tagged with its fetch address.
- It extracts RV32IC instructions (16-bit compressed or 32-bit, possibly straddling two words) and hands exactly one instruction per handshake to decode, with its PC and a compressed flag.
- It stores a residual upper halfword between fetch words.

Parameters:
- ADDR_WIDTH, 32, width of fetch/instruction address; only 32 supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- branch_i  in  1  flush: discard held halfword; incoming fetch word ignored this cycle
- fetch_valid_i  in  1  fetch word valid (prefetch valid_o)
- fetch_rdata_i  in  32  fetch word (prefetch rdata_o)
- fetch_addr_i  in  32  address tag of fetch word; bit1=1 only for halfword branch target
- fetch_ready_o  out  1  word consumed this cycle (prefetch ready_i)
- instr_valid_o  out  1  aligned instruction valid
- instr_ready_i  in  1  decode accepts instruction
- instr_rdata_o  out  32  instruction; compressed → {16'h0, half}
- instr_addr_o  out  32  PC of instruction
- instr_is_compressed_o  out  1  instr[1:0] != 2'b11
- busy_o  out  1  halfword held (state != S_ALIGNED)

Behaviour:
- State: S_ALIGNED (nothing held), S_HOLD (hold_q[15:0] and hold_addr_q valid). Reset: S_ALIGNED, hold_q=0, hold_addr_q=0.
- All outputs are combinational from state and fetch inputs. Zero-latency pass-through.
- Output fire = instr_valid_o & instr_ready_i. State and hold registers update only on fire, or on the consume-only case below.
- branch_i=1:
  - instr_valid_o=0 and fetch_ready_o=0.
  - Next state S_ALIGNED; hold is discarded.
  - Branch has priority over every other event.
- S_ALIGNED, fetch_valid_i=1, fetch_addr_i[1]=0:
  - lo=rdata[15:0], hi=rdata[31:16].
  - lo[1:0]!=11: output compressed lo @addr. On fire: fetch_ready_o=1, hold←hi, hold_addr←addr+2, → S_HOLD.
  - lo[1:0]==11: output full rdata @addr. On fire: fetch_ready_o=1, stay S_ALIGNED.
- S_ALIGNED, fetch_valid_i=1, fetch_addr_i[1]=1 (misaligned branch target):
  - hi compressed: output {16'h0,hi} @addr. On fire: consume, stay S_ALIGNED.
  - hi uncompressed: instr_valid_o=0, fetch_ready_o=1 unconditionally (consume-only), hold←hi, hold_addr←addr, → S_HOLD.
- S_HOLD, hold_q[1:0]!=11:
  - Output compressed hold @hold_addr. fetch_ready_o=0; the fetch word is irrelevant.
  - On fire → S_ALIGNED.
- S_HOLD, hold_q[1:0]==11:
  - Needs a fetch word: instr_valid_o=fetch_valid_i, rdata={fetch[15:0],hold_q}, addr=hold_addr_q.
  - On fire: fetch_ready_o=1, hold←fetch[31:16], hold_addr←hold_addr_q+4, stay S_HOLD.
- fetch_ready_o is never asserted without fetch_valid_i. A fetch word is never consumed without all of its halves being output or held.
- instr_valid_o held with instr_ready_i=0: all outputs are stable while inputs are stable.
- Address arithmetic: 32-bit modulo; 0xFFFF_FFFE+4 wraps to 0x0000_0002.
- Reset mid-operation clears hold immediately (async).

Decomposition:
- Shared package (zeroriscy_defines): state encoding S_ALIGNED=1'b0, S_HOLD=1'b1; constant OPCODE_UNCOMPRESSED=2'b11.
- Single module. Optional sub-module zeroriscy_is_compressed (2-bit combinational check) is not worth separating; inline it.

Test Plan:
- Aligned 32-bit stream: words 0x00000013 @0x100, 0x00100093 @0x104, ready=1 → two instrs, addr 0x100/0x104, compressed=0, each word consumed the same cycle.
- Two compressed in one word: 0x00010001 @0x200 → instr 0x00000001 @0x200 (word consumed), then 0x00000001 @0x202 from hold with fetch_ready_o=0, then S_ALIGNED.
- Straddling: 0x00130001 @0x300, 0x00000000 @0x304 → c.nop @0x300, then instr 0x00000013 @0x302 consuming the second word, hold=0x0000 @0x306.
- Misaligned branch target: fetch @0x402 data 0x00930000 → consume-only cycle with instr_valid_o=0; next word 0x00000010 @0x404 → instr 0x00100093 @0x402.
- Backpressure: instr_ready_i=0 for 3 cycles with compressed output pending → outputs stable, fetch_ready_o=0, no state change.
- Branch while S_HOLD plus async reset mid-stream → busy_o=0 next cycle; the next fetch word @new target is processed from S_ALIGNED.
